// File: rtl/jstk_pkg.sv
// Shared types and constants for the joystick polling scheduler:
// FSM state encoding, 40-bit frame field offsets/widths and the
// centre position used as the reset value of the X/Y outputs.
package jstk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_UNPACK    = 3'd4
  } state_t;

  localparam int FRAME_W = 40;
  localparam int POS_W   = 10;
  localparam int BTN_W   = 3;
  localparam int SUM_W   = 12;

  // Frame layout: byte0 [39:32] .. byte4 [7:0]
  localparam int X_LO_OFF = 32;  // byte0 -> x[7:0]
  localparam int X_HI_OFF = 24;  // byte1[1:0] -> x[9:8]
  localparam int Y_LO_OFF = 16;  // byte2 -> y[7:0]
  localparam int Y_HI_OFF = 8;   // byte3[1:0] -> y[9:8]
  localparam int BTN_OFF  = 0;   // byte4[2:0]

  // Bits that must be zero in a well-formed frame: [31:26], [15:10], [7:3]
  localparam logic [FRAME_W-1:0] RSVD_MASK = 40'h00_FC_00_FC_F8;

  localparam logic [POS_W-1:0] POS_CENTRE = 10'd512;

  function automatic logic frame_ok(input logic [FRAME_W-1:0] f);
    return (f & RSVD_MASK) == '0;
  endfunction

  function automatic logic [POS_W-1:0] get_x(input logic [FRAME_W-1:0] f);
    return {f[X_HI_OFF +: 2], f[X_LO_OFF +: 8]};
  endfunction

  function automatic logic [POS_W-1:0] get_y(input logic [FRAME_W-1:0] f);
    return {f[Y_HI_OFF +: 2], f[Y_LO_OFF +: 8]};
  endfunction

endpackage

// File: rtl/jstk_poll_sched_tick.sv
// poll_tick_gen: free-running divider. Counts 0..PERIOD-1 and emits a
// registered one-cycle tick in the cycle after the counter wraps.
module poll_tick_gen #(
  parameter int PERIOD = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  // Divider counter with registered wrap pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/jstk_poll_sched.sv
// jstk_poll_sched: requests one SPI joystick frame per poll period,
// supervises the transfer with a timeout, validates the 40-bit frame and
// publishes X/Y/buttons. Last good sample is held between polls.
//
// Handshake: spi_start is a one-cycle request pulse; the receiver answers
// with a one-cycle spi_done pulse, and spi_frame is only sampled in that
// cycle. There is no back-pressure; spi_done seen outside WAIT_DONE is
// dropped.
//
// Build option: define JSTK_AVG4_EN to output the mean of the last four
// valid samples instead of the raw position (history starts at centre).
module jstk_poll_sched
  import jstk_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int POLL_HZ     = 100,
  parameter int TIMEOUT_CYC = 200_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic               spi_start,
  input  logic               spi_done,
  input  logic [FRAME_W-1:0] spi_frame,
  output logic [POS_W-1:0]   x_pos,
  output logic [POS_W-1:0]   y_pos,
  output logic [BTN_W-1:0]   buttons,
  output logic               sample_valid,
  output logic               frame_err,
  output logic               timeout_err,
  output logic               overrun,
  output logic [2:0]         dbg_state
);

  localparam int PERIOD = CLK_HZ / POLL_HZ;
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic w_tick;
  logic w_accept;
  logic [POS_W-1:0] w_x_new;
  logic [POS_W-1:0] w_y_new;

  state_t           r_state;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_spi_start;
  logic [POS_W-1:0] r_x_pos;
  logic [POS_W-1:0] r_y_pos;
  logic [BTN_W-1:0] r_buttons;
  logic             r_sample_valid;
  logic             r_frame_err;
  logic             r_timeout_err;
  logic             r_overrun;

  poll_tick_gen #(
    .PERIOD (PERIOD)
  ) u_tick (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .o_tick  (w_tick)
  );

  // A frame is taken only when it arrives in WAIT_DONE and is well-formed
  assign w_accept = (r_state == ST_WAIT_DONE) && spi_done && frame_ok(spi_frame);

`ifdef JSTK_AVG4_EN
  // Three previous accepted samples; the fourth term is the arriving one
  logic [POS_W-1:0] r_hx [3];
  logic [POS_W-1:0] r_hy [3];
  logic [SUM_W-1:0] w_x_sum;
  logic [SUM_W-1:0] w_y_sum;

  // Running 4-sample sums, truncated mean
  always_comb begin
    w_x_sum = SUM_W'(get_x(spi_frame)) + SUM_W'(r_hx[0]) + SUM_W'(r_hx[1]) + SUM_W'(r_hx[2]);
    w_y_sum = SUM_W'(get_y(spi_frame)) + SUM_W'(r_hy[0]) + SUM_W'(r_hy[1]) + SUM_W'(r_hy[2]);
    w_x_new = w_x_sum[SUM_W-1:2];
    w_y_new = w_y_sum[SUM_W-1:2];
  end

  // Shift accepted samples into the history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        r_hx[i] <= POS_CENTRE;
        r_hy[i] <= POS_CENTRE;
      end
    end else if (w_accept) begin
      r_hx[0] <= get_x(spi_frame);
      r_hy[0] <= get_y(spi_frame);
      r_hx[1] <= r_hx[0];
      r_hy[1] <= r_hy[0];
      r_hx[2] <= r_hx[1];
      r_hy[2] <= r_hy[1];
    end
  end
`else
  // Raw unpacked position
  always_comb begin
    w_x_new = get_x(spi_frame);
    w_y_new = get_y(spi_frame);
  end
`endif

  // Scheduler FSM with registered request, data and status pulses.
  // The frame is checked as spi_done arrives so results are visible in
  // UNPACK, one cycle after the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_to_cnt       <= '0;
      r_spi_start    <= 1'b0;
      r_x_pos        <= POS_CENTRE;
      r_y_pos        <= POS_CENTRE;
      r_buttons      <= '0;
      r_sample_valid <= 1'b0;
      r_frame_err    <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_spi_start    <= 1'b0;
      r_sample_valid <= 1'b0;
      r_frame_err    <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_overrun      <= w_tick && (r_state == ST_START || r_state == ST_WAIT_DONE ||
                                   r_state == ST_UNPACK);
      case (r_state)
        ST_IDLE: begin
          if (enable) r_state <= ST_WAIT_TICK;
        end
        ST_WAIT_TICK: begin
          if (!enable) begin
            r_state <= ST_IDLE;
          end else if (w_tick) begin
            r_state     <= ST_START;
            r_spi_start <= 1'b1;
            r_to_cnt    <= '0;
          end
        end
        ST_START: begin
          // Timeout window counts from the spi_start cycle itself
          r_to_cnt <= r_to_cnt + TO_W'(1);
          r_state  <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (spi_done) begin
            r_state <= ST_UNPACK;
            if (frame_ok(spi_frame)) begin
              r_x_pos        <= w_x_new;
              r_y_pos        <= w_y_new;
              r_buttons      <= spi_frame[BTN_OFF +: BTN_W];
              r_sample_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else if (r_to_cnt == TO_LAST) begin
            r_timeout_err <= 1'b1;
            r_state       <= ST_WAIT_TICK;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        ST_UNPACK: begin
          r_state <= enable ? ST_WAIT_TICK : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign spi_start    = r_spi_start;
  assign x_pos        = r_x_pos;
  assign y_pos        = r_y_pos;
  assign buttons      = r_buttons;
  assign sample_valid = r_sample_valid;
  assign frame_err    = r_frame_err;
  assign timeout_err  = r_timeout_err;
  assign overrun      = r_overrun;
  assign dbg_state    = r_state;

endmodule
